// File: rtl/switch_allocator_pkg.sv
// rtl/switch_allocator_pkg.sv - shared router constants for the switch allocator
// Purpose: sizes of the 7-port x 4-VC router, flit width and port indices.
// Ports: none (package).
package switch_allocator_pkg;

   localparam int FLIT_SIZE   = 32;
   localparam int VC_PER_PORT = 4;
   localparam int N_OUT       = 7;
   localparam int M_IN        = N_OUT * VC_PER_PORT;
   localparam int PORT_W      = $clog2(N_OUT);
   localparam int IDX_W       = $clog2(M_IN);

   typedef enum logic [PORT_W-1:0] {
      PORT_LOCAL = 3'd0,
      PORT_NORTH = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_SOUTH = 3'd3,
      PORT_WEST  = 3'd4,
      PORT_UP    = 3'd5,
      PORT_DOWN  = 3'd6
   } port_e;

   // Bit position of the crosspoint routing input i to output j.
   function automatic int xp_index(input int i, input int j);
      return i * N_OUT + j;
   endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rtl/switch_allocator_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first set request at or after ptr, wrapping at M_in.
// Ports: req [M_in] requests, ptr [clog2(M_in)] search start, gnt [M_in] one-hot grant.
module rr_arbiter #(
   parameter int M_in  = 28,
   parameter int PTR_W = $clog2(M_in)
) (
   input  logic [M_in-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [M_in-1:0]  gnt
);

   logic [M_in-1:0]   hi_mask;
   logic [2*M_in-1:0] dbl;
   logic              found;

   // Requests at or above ptr sit in the low half and are found first;
   // the unmasked copy in the high half supplies the wrapped search.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < M_in; i++) begin
         hi_mask[i] = (i >= int'(ptr));
      end
   end

   assign dbl = {req, req & hi_mask};

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < 2 * M_in; k++) begin
         if (!found && dbl[k]) begin
            found          = 1'b1;
            gnt[k % M_in]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - wormhole switch allocator with per-output packet locks
// Purpose: match input-VC requests to output ports, drive crosspoints and pops.
// Ports: clk, rst_n (async, active-low);
//        req_valid/req_tail [M_in], req_port [M_in*PORT_W], out_ready [N_out];
//        grant [M_in] pop strobes, xpoints_enable [M_in*N_out] bit i*N_out+j.
module switch_allocator
   import switch_allocator_pkg::*;
#(
   parameter int M_in  = M_IN,
   parameter int N_out = N_OUT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [M_in-1:0]         req_valid,
   input  logic [M_in*PORT_W-1:0]  req_port,
   input  logic [M_in-1:0]         req_tail,
   input  logic [N_out-1:0]        out_ready,
   output logic [M_in-1:0]         grant,
   output logic [M_in*N_out-1:0]   xpoints_enable
);

   localparam int IW = $clog2(M_in);

   logic [N_out-1:0] lock_vld;
   logic [IW-1:0]    lock_own [N_out];
   logic [IW-1:0]    rr_ptr   [N_out];

   logic [M_in-1:0]  elig     [N_out];
   logic [M_in-1:0]  arb_req  [N_out];
   logic [M_in-1:0]  arb_gnt  [N_out];
   logic [M_in-1:0]  win      [N_out];
   logic [IW-1:0]    win_idx  [N_out];
   logic [N_out-1:0] won;

   // A port index >= N_out never matches any j, so such requests are dropped here.
   always_comb begin
      for (int j = 0; j < N_out; j++) begin
         for (int i = 0; i < M_in; i++) begin
            elig[j][i] = req_valid[i] && out_ready[j] &&
                         (req_port[i*PORT_W +: PORT_W] == PORT_W'(j));
         end
         arb_req[j] = lock_vld[j] ? '0 : elig[j];
      end
   end

   for (genvar g = 0; g < N_out; g++) begin : g_arb
      rr_arbiter #(.M_in(M_in)) u_arb (
         .req (arb_req[g]),
         .ptr (rr_ptr[g]),
         .gnt (arb_gnt[g])
      );
   end

   // A locked output bypasses the arbiter: only the owner can win it.
   always_comb begin
      for (int j = 0; j < N_out; j++) begin
         win[j] = '0;
         if (lock_vld[j]) begin
            win[j][lock_own[j]] = elig[j][lock_own[j]];
         end else begin
            win[j] = arb_gnt[j];
         end
         won[j]     = |win[j];
         win_idx[j] = '0;
         for (int i = 0; i < M_in; i++) begin
            if (win[j][i]) begin
               win_idx[j] = IW'(i);
            end
         end
      end
   end

   always_comb begin
      grant          = '0;
      xpoints_enable = '0;
      if (rst_n) begin
         for (int j = 0; j < N_out; j++) begin
            for (int i = 0; i < M_in; i++) begin
               grant[i]                 |= win[j][i];
               xpoints_enable[i*N_out+j] = win[j][i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_vld <= '0;
         for (int j = 0; j < N_out; j++) begin
            lock_own[j] <= '0;
            rr_ptr[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < N_out; j++) begin
            if (won[j]) begin
               // The pointer only advances on arbitrated (unlocked) grants.
               if (!lock_vld[j]) begin
                  rr_ptr[j] <= (win_idx[j] == IW'(M_in - 1)) ? '0 : win_idx[j] + 1'b1;
               end
               if (req_tail[win_idx[j]]) begin
                  lock_vld[j] <= 1'b0;
               end else if (!lock_vld[j]) begin
                  lock_vld[j] <= 1'b1;
                  lock_own[j] <= win_idx[j];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - self-checking bench for switch_allocator
module tb_switch_allocator;

   localparam int M  = 28;
   localparam int N  = 7;
   localparam int PW = 3;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [M-1:0]    req_valid = '0;
   logic [M-1:0]    req_tail  = '0;
   logic [N-1:0]    out_ready = '1;
   logic [M*PW-1:0] req_port;
   logic [M-1:0]    grant;
   logic [M*N-1:0]  xpoints_enable;
   logic [PW-1:0]   rp [M];

   int checks = 0;
   int errors = 0;

   switch_allocator dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_port       (req_port),
      .req_tail       (req_tail),
      .out_ready      (out_ready),
      .grant          (grant),
      .xpoints_enable (xpoints_enable)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_port = '0;
      for (int i = 0; i < M; i++) req_port[i*PW +: PW] = rp[i];
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: per output, either a known packet owner or a
   // round-robin search starting at the remembered position.
   bit m_locked [N];
   int m_owner  [N];
   int m_ptr    [N];
   int m_win    [N];

   function automatic bit eligible(input int i, input int j);
      return req_valid[i] && (int'(rp[i]) == j) && out_ready[j];
   endfunction

   function automatic void model_eval();
      for (int j = 0; j < N; j++) begin
         m_win[j] = -1;
         if (m_locked[j]) begin
            if (eligible(m_owner[j], j)) m_win[j] = m_owner[j];
         end else begin
            for (int k = 0; k < M; k++) begin
               int i;
               i = (m_ptr[j] + k) % M;
               if (eligible(i, j)) begin
                  m_win[j] = i;
                  break;
               end
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N; j++) begin
            m_locked[j] = 1'b0;
            m_owner[j]  = 0;
            m_ptr[j]    = 0;
         end
      end else begin
         model_eval();
         for (int j = 0; j < N; j++) begin
            if (m_win[j] >= 0) begin
               if (!m_locked[j]) m_ptr[j] = (m_win[j] + 1) % M;
               if (req_tail[m_win[j]]) begin
                  m_locked[j] = 1'b0;
               end else if (!m_locked[j]) begin
                  m_locked[j] = 1'b1;
                  m_owner[j]  = m_win[j];
               end
            end
         end
      end
   end

   logic [M-1:0]   exp_g;
   logic [M*N-1:0] exp_x;

   always @(negedge clk) begin
      model_eval();
      exp_g = '0;
      exp_x = '0;
      if (rst_n === 1'b1) begin
         for (int j = 0; j < N; j++) begin
            if (m_win[j] >= 0) begin
               exp_g[m_win[j]]       = 1'b1;
               exp_x[m_win[j]*N + j] = 1'b1;
            end
         end
      end
      chk("cmp_grant", grant, exp_g);
      chk("cmp_xpoints", xpoints_enable, exp_x);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_tail  = '0;
      out_ready = '1;
      for (int i = 0; i < M; i++) rp[i] = '0;
   endtask

   task automatic set_req(input int i, input int port, input bit tail);
      req_valid[i] = 1'b1;
      rp[i]        = PW'(port);
      req_tail[i]  = tail;
   endtask

   logic [M-1:0] one;
   logic [N-1:0] col_ok;
   int           rr_exp [4] = '{0, 4, 9, 0};

   initial begin
      one = M'(1);
      clear_inputs();
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", grant, 0);
      chk("reset_xpoints", xpoints_enable, 0);
      rst_n = 1'b1;
      clear_inputs();
      tick();

      // Single-flit request, then a second requester proves no lock remained.
      set_req(5, 2, 1'b1);
      #1;
      chk("single_grant", grant, one << 5);
      chk("single_xpt", xpoints_enable, {{(M*N-1){1'b0}}, 1'b1} << 37);
      tick();
      clear_inputs();
      set_req(9, 2, 1'b1);
      #1;
      chk("no_lock", grant, one << 9);
      tick();

      clear_inputs();
      set_req(0, 3, 1'b1);
      set_req(4, 3, 1'b1);
      set_req(9, 3, 1'b1);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("rr_%0d", c), grant, one << rr_exp[c]);
         tick();
      end

      // Four-flit packet from input 8 on port 1, with a 3-cycle stall.
      clear_inputs();
      set_req(8, 1, 1'b0);
      #1; chk("wh_head", grant, one << 8); tick();
      set_req(2, 1, 1'b1);
      #1; chk("wh_body1", grant, one << 8); tick();
      out_ready[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1; chk("bp_stall", grant, 0); tick();
      end
      out_ready[1] = 1'b1;
      #1; chk("wh_body2", grant, one << 8); tick();
      req_tail[8] = 1'b1;
      #1; chk("wh_tail", grant, one << 8); tick();
      req_valid[8] = 1'b0;
      #1; chk("wh_next", grant, one << 2); tick();

      // Reset in the middle of a locked packet.
      clear_inputs();
      set_req(8, 1, 1'b0);
      set_req(2, 1, 1'b1);
      #1; chk("rst_head", grant, one << 8); tick();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_grant", grant, 0);
      chk("rst_async_xpt", xpoints_enable, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1; chk("rst_fresh", grant, one << 2); tick();
      clear_inputs();
      tick();

      // Full load: every output sees four requesters.
      for (int i = 0; i < M; i++) set_req(i, i % N, 1'b1);
      #1; chk("fl_first", grant, 28'h000017D);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("fl_count", $countones(grant), 7);
         col_ok = '0;
         for (int j = 0; j < N; j++) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < M; i++) cnt += int'(xpoints_enable[i*N + j]);
            col_ok[j] = (cnt == 1);
         end
         chk("fl_cols", col_ok, 7'h7F);
         tick();
      end

      // Out-of-range port requests.
      clear_inputs();
      set_req(27, 7, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("inv_grant", grant, 0);
         chk("inv_xpt", xpoints_enable, 0);
         tick();
      end
      for (int i = 0; i < M; i++) set_req(i, i % N, 1'b1);
      rp[6] = 3'd7;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("mix_count", $countones(grant), 7);
         chk("mix_inv", grant[6], 0);
         tick();
      end

      clear_inputs();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
